data_memory_responder: RTL

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/dmem_pkg.sv | 6 +
 rtl/data_memory_responder_if.sv | 18 +
 rtl/dmem_array.sv | 32 +++
 rtl/data_memory_responder.sv | 86 ++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and default geometry for data_memory_responder
package dmem_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  typedef enum logic [1:0] {HOST, RUN, DONE} state_t;
endpackage

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: host request/response bus
// master drives HOST_VALID/HOST_WRITE/HOST_ADDR/HOST_WDATA; slave drives HOST_READY/HOST_RVALID/HOST_RDATA
interface data_memory_responder_if import dmem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              HOST_VALID;
  logic              HOST_WRITE;
  logic [ADDR_W-1:0] HOST_ADDR;
  logic [DATA_W-1:0] HOST_WDATA;
  logic              HOST_READY;
  logic              HOST_RVALID;
  logic [DATA_W-1:0] HOST_RDATA;
  modport master (output HOST_VALID, HOST_WRITE, HOST_ADDR, HOST_WDATA,
                  input  HOST_READY, HOST_RVALID, HOST_RDATA);
  modport slave  (input  HOST_VALID, HOST_WRITE, HOST_ADDR, HOST_WDATA,
                  output HOST_READY, HOST_RVALID, HOST_RDATA);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-write-port word array with registered, write-first read outputs
// clk/rst_n; i_we/i_addr/i_wdata write port; i_cpu_ld/i_host_ld load o_cpu_rdata/o_host_rdata;
// i_zero forces the loaded value to 0 (out-of-range CPU access)
module dmem_array import dmem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_cpu_ld,
  input  logic              i_host_ld,
  input  logic              i_zero,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic [DATA_W-1:0] o_host_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] w_rd;
  assign w_rd = i_zero ? '0 : i_we ? i_wdata : r_mem[i_addr];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_cpu_rdata  <= '0;
      o_host_rdata <= '0;
    end else begin
      if (i_cpu_ld) o_cpu_rdata <= w_rd;
      if (i_host_ld) o_host_rdata <= w_rd;
    end
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: word memory shared between a host port and a ticked processor
// MAIN_CLOCK/RESET_N clock and async active-low reset; CPU_* processor access, DATA_FROM_RAM read data;
// HOST_START releases the processor; host bus via data_memory_responder_if.slave;
// RUN_ACTIVE, sticky ADDR_ERR; READ_COUNT/WRITE_COUNT live only with DMEM_ACCESS_COUNT_EN, else 0
module data_memory_responder import dmem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              MAIN_CLOCK,
  input  logic              RESET_N,
  input  logic              CPU_CLOCK,
  input  logic [15:0]       CPU_ADDRESS,
  input  logic [DATA_W-1:0] CPU_DATA,
  input  logic              CPU_WRITE_EN,
  input  logic              PROCESS_FINISHED,
  input  logic              HOST_START,
  output logic [DATA_W-1:0] DATA_FROM_RAM,
  output logic              RUN_ACTIVE,
  output logic              ADDR_ERR,
  output logic [15:0]       READ_COUNT,
  output logic [15:0]       WRITE_COUNT,
  data_memory_responder_if.slave host
);
  state_t r_state, w_next;
  logic r_cpu_clk_q, r_addr_err, r_rvalid;
  logic w_run, w_tick, w_acc, w_oor, w_xfer, w_start, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata, w_host_rdata;
  assign w_run   = r_state == RUN;
  assign w_tick  = CPU_CLOCK & ~r_cpu_clk_q;
  assign w_acc   = w_run & w_tick;
  assign w_oor   = (CPU_ADDRESS >> ADDR_W) != '0;
  assign w_xfer  = host.HOST_VALID & ~w_run;
  // a start seen while running is ignored, so it must not clear the flag or counters
  assign w_start = HOST_START & ~w_run;
  assign w_we    = w_run ? w_acc & CPU_WRITE_EN & ~w_oor : w_xfer & host.HOST_WRITE;
  assign w_addr  = w_run ? CPU_ADDRESS[ADDR_W-1:0] : host.HOST_ADDR;
  assign w_wdata = w_run ? CPU_DATA : host.HOST_WDATA;
  always_comb begin
    w_next = r_state;
    if (w_run) w_next = PROCESS_FINISHED ? DONE : RUN;
    else if (HOST_START) w_next = RUN;
  end
  always_ff @(posedge MAIN_CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      r_state     <= HOST;
      r_cpu_clk_q <= 1'b0;
      r_addr_err  <= 1'b0;
      r_rvalid    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cpu_clk_q <= CPU_CLOCK;
      r_rvalid    <= w_xfer & ~host.HOST_WRITE;
      r_addr_err  <= w_start ? 1'b0 : r_addr_err | (w_acc & w_oor);
    end
  dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk(MAIN_CLOCK), .rst_n(RESET_N),
    .i_we(w_we), .i_addr(w_addr), .i_wdata(w_wdata),
    .i_cpu_ld(w_acc), .i_host_ld(w_xfer & ~host.HOST_WRITE), .i_zero(w_run & w_oor),
    .o_cpu_rdata(DATA_FROM_RAM), .o_host_rdata(w_host_rdata)
  );
  assign host.HOST_READY  = ~w_run;
  assign host.HOST_RVALID = r_rvalid;
  assign host.HOST_RDATA  = w_host_rdata;
  assign RUN_ACTIVE       = w_run;
  assign ADDR_ERR         = r_addr_err;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [15:0] r_rd_cnt, r_wr_cnt;
  always_ff @(posedge MAIN_CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_start) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_acc) begin
      if (CPU_WRITE_EN) r_wr_cnt <= r_wr_cnt + {15'd0, ~&r_wr_cnt};
      else r_rd_cnt <= r_rd_cnt + {15'd0, ~&r_rd_cnt};
    end
  assign READ_COUNT  = r_rd_cnt;
  assign WRITE_COUNT = r_wr_cnt;
`else
  assign READ_COUNT  = '0;
  assign WRITE_COUNT = '0;
`endif
endmodule
